// File: rtl/burst_gate_sequencer_if.sv
// Signal bundle between the sync slicer / burst-error source and the burst gate sequencer.
// Every signal is level-sampled on each clk edge; there is no valid/ready handshake on this bus.
interface burst_gate_sequencer_if;
  logic               sync_in;
  logic signed [11:0] error_in;
  logic               burst_active;
  logic               line_start;
  logic               sync_lost;
  logic               locked;
  logic [2:0]         state_dbg;

  modport master (
    output sync_in, error_in,
    input  burst_active, line_start, sync_lost, locked, state_dbg
  );

  modport slave (
    input  sync_in, error_in,
    output burst_active, line_start, sync_lost, locked, state_dbg
  );
endinterface

// File: rtl/burst_gate_sequencer.sv
// Validates hsync pulses, opens the chroma burst gate at a fixed offset after the sync
// trailing edge, and tracks line timing, sync loss and burst-PLL lock.
module burst_gate_sequencer #(
  parameter int SYNC_MIN     = 40,
  parameter int SYNC_MAX     = 120,
  parameter int BURST_START  = 20,
  parameter int BURST_LEN    = 36,
  parameter int LINE_TIMEOUT = 1000,
  parameter int LOCK_THRESH  = 64,
  parameter int LOCK_LINES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_gate_sequencer_if.slave bus
);

  localparam int WW = $clog2(SYNC_MAX + 1);
  localparam int DW = $clog2(BURST_START + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(LINE_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [WW-1:0] WIDTH_LAST = WW'(SYNC_MAX - 1);
  localparam logic [WW-1:0] WIDTH_MIN  = WW'(SYNC_MIN);
  localparam logic [DW-1:0] DELAY_LAST = DW'(BURST_START - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT    = TW'(LINE_TIMEOUT);
  localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_LINES);
  localparam logic [12:0]   THRESH     = 13'(LOCK_THRESH);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_SYNC  = 3'd1,
    S_BROAD = 3'd2,
    S_DELAY = 3'd3,
    S_BURST = 3'd4
  } state_t;

  state_t      state;
  logic [WW-1:0] width;
  logic [DW-1:0] dly_cnt;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] line_tmr;
  logic [GW-1:0] good_cnt;
  logic [12:0]   peak;
  logic          burst_active_q;
  logic          line_start_q;
  logic          sync_lost_q;
  logic          locked_q;

  logic signed [12:0] err_ext;
  logic [12:0]        err_abs;
  logic [12:0]        peak_next;
  logic               hsync;
  logic               burst_good;

  // 13-bit magnitude so that |-2048| is representable.
  always_comb begin
    err_ext    = {bus.error_in[11], bus.error_in};
    err_abs    = err_ext[12] ? 13'(-err_ext) : 13'(err_ext);
    peak_next  = (err_abs > peak) ? err_abs : peak;
    burst_good = (peak_next < THRESH);
    hsync      = (state == S_SYNC) && !bus.sync_in && (width >= WIDTH_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_WAIT;
      width          <= '0;
      dly_cnt        <= '0;
      burst_cnt      <= '0;
      line_tmr       <= '0;
      good_cnt       <= '0;
      peak           <= '0;
      burst_active_q <= 1'b0;
      line_start_q   <= 1'b0;
      sync_lost_q    <= 1'b1;
      locked_q       <= 1'b0;
    end else begin
      line_start_q <= 1'b0;
      case (state)
        S_WAIT: begin
          if (bus.sync_in) begin
            state <= S_SYNC;
            width <= WW'(1);
          end
        end
        S_SYNC: begin
          if (bus.sync_in) begin
            if (width == WIDTH_LAST) state <= S_BROAD;
            width <= width + WW'(1);
          end else if (hsync) begin
            line_start_q <= 1'b1;
            dly_cnt      <= '0;
            state        <= S_DELAY;
          end else begin
            state <= S_WAIT;
          end
        end
        S_BROAD: begin
          if (!bus.sync_in) state <= S_WAIT;
        end
        S_DELAY: begin
          if (bus.sync_in) begin
            state <= S_SYNC;
            width <= WW'(1);
          end else if (dly_cnt == DELAY_LAST) begin
            state          <= S_BURST;
            burst_active_q <= 1'b1;
            burst_cnt      <= '0;
            peak           <= '0;
          end else begin
            dly_cnt <= dly_cnt + DW'(1);
          end
        end
        S_BURST: begin
          // A new sync edge inside the window wins, even on its last cycle.
          if (bus.sync_in) begin
            state          <= S_SYNC;
            width          <= WW'(1);
            burst_active_q <= 1'b0;
            good_cnt       <= '0;
            locked_q       <= 1'b0;
          end else begin
            peak <= peak_next;
            if (burst_cnt == BURST_LAST) begin
              state          <= S_WAIT;
              burst_active_q <= 1'b0;
              if (burst_good) begin
                if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + GW'(1);
                locked_q <= (good_cnt >= GOOD_MAX - GW'(1));
              end else begin
                good_cnt <= '0;
                locked_q <= 1'b0;
              end
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
        end
        default: begin
          state          <= S_WAIT;
          burst_active_q <= 1'b0;
        end
      endcase

      // Line timer sits after the FSM so a timeout overrides any lock update.
      if (hsync) begin
        line_tmr    <= '0;
        sync_lost_q <= 1'b0;
      end else if (line_tmr == TIMEOUT) begin
        sync_lost_q <= 1'b1;
        good_cnt    <= '0;
        locked_q    <= 1'b0;
      end else begin
        line_tmr <= line_tmr + TW'(1);
      end
    end
  end

  assign bus.burst_active = burst_active_q;
  assign bus.line_start   = line_start_q;
  assign bus.sync_lost    = sync_lost_q;
  assign bus.locked       = locked_q;
  assign bus.state_dbg    = state;

endmodule

// File: doc/burst_gate_sequencer.md
# burst_gate_sequencer

Sequences the chroma-burst phase-locked loop by deciding, per scan line, when the loop filter accumulates burst error. It sits between the composite sync slicer and the loop filter. It validates horizontal sync pulses and rejects equalizing and broad (vertical) pulses. For each valid line it opens a `burst_active` window at a fixed offset from the sync trailing edge, and it reports line timing, sync loss and PLL lock status to the rest of the decoder.

## Interface
- `SYNC_MIN`, 40: minimum sync-high width in clk cycles for a valid hsync.
- `SYNC_MAX`, 120: sync-high width at which the pulse is classified as broad/vertical.
- `BURST_START`, 20: cycles from the sync trailing edge to burst window open.
- `BURST_LEN`, 36: burst window length in cycles.
- `LINE_TIMEOUT`, 1000: cycles without a valid hsync before `sync_lost` asserts.
- `LOCK_THRESH`, 64: per-burst peak |error| limit for a "good" line.
- `LOCK_LINES`, 16: consecutive good lines required for `locked`.

Ports:
- `clk` in 1: sample clock.
- `rst` in 1: reset; asynchronous, active-high.
- `sync_in` in 1: sliced composite sync, 1 = sync tip, already synchronous to clk.
- `error_in` in 12 signed: burst error, i.e. the red component during burst. Same signal the loop filter consumes.
- `burst_active` out 1: burst gate to the loop filter.
- `line_start` out 1: one-cycle pulse per valid hsync.
- `sync_lost` out 1: no valid hsync within `LINE_TIMEOUT`.
- `locked` out 1: chroma PLL considered locked.

## Operation
- FSM states are WAIT, SYNC, BROAD, DELAY and BURST. All outputs are registered.
- **WAIT**: when `sync_in`=1, go to SYNC with width counter = 1.
- **SYNC**:
  - While `sync_in`=1, increment the width counter.
  - If the width counter reaches `SYNC_MAX`, go to BROAD.
  - On `sync_in`=0 with width ≥ `SYNC_MIN`: valid hsync. Pulse `line_start`, clear the line timer, go to DELAY.
  - On `sync_in`=0 with width < `SYNC_MIN`: go to WAIT with no `line_start`.
- **BROAD**: stay until `sync_in`=0, then go to WAIT. BROAD never produces `line_start` or a burst.
- **DELAY**: count `BURST_START` cycles, then go to BURST. If `sync_in`=1, abort to SYNC (width = 1).
- **BURST**:
  - `burst_active`=1 for `BURST_LEN` cycles, then go to WAIT.
  - If `sync_in`=1, abort to SYNC with width = 1. `burst_active` drops the next cycle and the burst is "aborted".
- **Peak tracking**: during BURST, track peak = max(|`error_in`|), computed 13 bits wide so that |−2048| = 2048. Peak resets at BURST entry.
- **Lock counter** (sat at `LOCK_LINES`), updated at completed burst end:
  - Peak < `LOCK_THRESH`: good_cnt increments, saturating.
  - Otherwise: good_cnt clears.
  - An aborted burst clears good_cnt.
  - `locked` = (good_cnt == `LOCK_LINES`).
- **Line timer**:
  - Free-running and saturating. Cleared on valid hsync.
  - When it reaches `LINE_TIMEOUT`, `sync_lost`←1 and good_cnt←0.
  - `sync_lost`←0 on the next valid hsync.
  - If the timeout and a valid hsync occur on the same cycle, the hsync wins.
- **Reset, at any time including mid-burst**: state WAIT, all counters 0, `burst_active`=0, `line_start`=0, `sync_lost`=1, `locked`=0.

## Timing
- Let T be the first cycle with `sync_in` sampled 0 after a valid-width pulse.
- `line_start`=1 during cycle T+1 only.
- `burst_active`=1 during cycles T+1+`BURST_START` through T+`BURST_START`+`BURST_LEN`, inclusive. That is exactly `BURST_LEN` cycles.
- `locked` and good_cnt update in the cycle after the last `burst_active` cycle.
- Sync-width boundary:
  - Width is the number of `sync_in`=1 samples.
  - Width = `SYNC_MIN` is valid.
  - Width = `SYNC_MAX` enters BROAD on the cycle the counter hits `SYNC_MAX`.
- `sync_in` rising in the last BURST cycle still counts as an abort.
- The `sync_lost` rise is registered: the line timer equals `LINE_TIMEOUT` at cycle N, and `sync_lost`=1 from N+1.

## Test plan
- **Nominal hsync**: sync high for 60 cycles, falling at T, then low. Required: `line_start` high only at T+1; `burst_active` high for exactly 36 cycles, T+21..T+56.
- **Equalizing pulse**: sync high for 30 cycles. Required: no `line_start`, `burst_active` stays 0. With sync high for exactly 40 cycles, the line is valid.
- **Broad pulse**: sync high for 200 cycles. Required: no `line_start` and no burst. A following 60-cycle pulse yields a normal burst.
- **Lock acquisition**: 16 lines with `error_in`=±50. Required: `locked`=1 after the 16th burst end. Then one line containing a single sample of −2048: `locked`=0 the cycle after that burst ends.
- **Aborted burst**: `sync_in`=1 at burst cycle 10. Required: `burst_active` falls the next cycle and good_cnt clears.
- **Sync loss and reset**:
  - After reset, `sync_lost`=1.
  - One valid line clears it.
  - 1000 idle cycles re-assert it and clear `locked`.
  - `rst` asserted mid-burst drops `burst_active` immediately.
